// File: rtl/apb_uart_master.sv
// APB3 requester: turns one register command into one APB transfer and one response.
// Latency: response valid 2 cycles after command acceptance plus one cycle per PREADY-low cycle.
// Backpressure: cmd_ready is high only in IDLE; the response is held until rsp_ready.
module apb_uart_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic        PSEL,
  output logic        PENABLE,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT_CYCLES);

  state_t      r_state;
  logic [15:0] r_wait_cnt;
  logic [31:0] r_paddr;
  logic [31:0] r_pwdata;
  logic        r_pwrite;
  logic        r_psel;
  logic        r_penable;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic        r_rsp_timeout;

  logic [15:0] w_cnt_inc;
  logic        w_timeout_hit;

  // Saturating wait count and the abort condition for a PREADY-low ACCESS cycle
  always_comb begin
    w_cnt_inc     = (r_wait_cnt == 16'hFFFF) ? r_wait_cnt : (r_wait_cnt + 16'd1);
    w_timeout_hit = (LP_TIMEOUT != 16'd0) && (w_cnt_inc == LP_TIMEOUT);
  end

  // Transfer FSM with registered APB and response outputs
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= 16'd0;
      r_paddr       <= 32'd0;
      r_pwdata      <= 32'd0;
      r_pwrite      <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= 32'd0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_pwrite   <= cmd_write;
            r_paddr    <= cmd_addr;
            r_pwdata   <= cmd_wdata;
            r_wait_cnt <= 16'd0;
            r_psel     <= 1'b1;
            r_penable  <= 1'b0;
            r_state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (PREADY) begin
            // Completion wins over a timeout landing in the same cycle
            r_rsp_rdata   <= r_pwrite ? 32'd0 : PRDATA;
            r_rsp_err     <= PSLVERR;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_state       <= S_RESP;
          end else begin
            r_wait_cnt <= w_cnt_inc;
            if (w_timeout_hit) begin
              r_rsp_rdata   <= 32'd0;
              r_rsp_err     <= 1'b1;
              r_rsp_timeout <= 1'b1;
              r_rsp_valid   <= 1'b1;
              r_psel        <= 1'b0;
              r_penable     <= 1'b0;
              r_state       <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_psel      <= 1'b0;
          r_penable   <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // cmd_ready is gated by reset so it is low while PRESETn is asserted
  assign cmd_ready   = (r_state == S_IDLE) && PRESETn;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign PWRITE      = r_pwrite;
  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;

endmodule
